bus_align_unit: RTL and testbench

- Parametrised successor to the current byte/word bus controller.
- Sits between the CPU load/store path and the aligned memory bus, with a req/done handshake on the CPU side and a req/ready handshake on the memory side.
- Handles byte and full-word accesses at any byte address. A misaligned word is split into two aligned memory beats, with byte-lane rotation and byte enables.
- Byte loads are sign- or zero-extended.

---
 rtl/bus_align_unit.sv | 181 ++++++++++++++++++
 tb/tb_bus_align_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_align_unit.sv
// bus_align_unit: byte/word CPU accesses onto an aligned memory bus; misaligned words become two beats.
// Build macro MISALIGN_TRAP_EN: misaligned words complete at once with fault=1 instead of being split.
module bus_align_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic                word,
    input  logic                sign_extend,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                done,
    output logic                busy,
    output logic                fault,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    state_t state_q, state_d;

    logic              we_q, word_q, sx_q;
    logic [ADDR_W-1:0] addr_q, a0;
    logic [DATA_W-1:0] wdata_q, beat0_q, rdata_q, merged;
    logic [OFF_W-1:0]  off_q;
    logic              split_q;
    logic [NB-1:0]     hi_mask;

    assign off_q   = addr_q[OFF_W-1:0];
    assign split_q = word_q & (off_q != '0);
    assign a0      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // hi_mask marks the lanes served by the first beat of a split access
    always_comb begin
        hi_mask = '0;
        merged  = '0;
        for (int l = 0; l < NB; l++) begin
            hi_mask[l] = (OFF_W'(l) >= off_q);
            merged[l*8 +: 8] = hi_mask[l] ? beat0_q[l*8 +: 8] : mem_rdata[l*8 +: 8];
        end
    end

    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] d, input logic [OFF_W-1:0] o);
        logic [DATA_W-1:0] r;
        logic [OFF_W-1:0]  l;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            l = OFF_W'(i) + o;
            r[int'(l)*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] assemble(input logic [DATA_W-1:0] lanes, input logic [OFF_W-1:0] o,
                                                   input logic wd, input logic sx);
        logic [DATA_W-1:0] r;
        logic [OFF_W-1:0]  l;
        logic [7:0]        b;
        r = '0;
        if (wd) begin
            for (int i = 0; i < NB; i++) begin
                l = OFF_W'(i) + o;
                r[i*8 +: 8] = lanes[int'(l)*8 +: 8];
            end
        end else begin
            b = lanes[int'(o)*8 +: 8];
            r = {{(DATA_W-8){sx & b[7]}}, b};
        end
        return r;
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic fault_q;
    logic split_in;
    assign split_in = word & (addr[OFF_W-1:0] != '0);
    assign fault    = (state_q == RESP) & fault_q;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
`ifdef MISALIGN_TRAP_EN
                    state_d = split_in ? RESP : BEAT0;
`else
                    state_d = BEAT0;
`endif
                end
            end
            BEAT0: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = a0;
                mem_wdata = rotl(wdata_q, off_q);
                if (!word_q)      mem_be = {{(NB-1){1'b0}}, 1'b1} << off_q;
                else if (split_q) mem_be = hi_mask;
                else              mem_be = '1;
                if (mem_ready) state_d = split_q ? BEAT1 : RESP;
            end
            BEAT1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = a0 + ADDR_W'(NB);
                mem_wdata = rotl(wdata_q, off_q);
                mem_be    = ~hi_mask;
                if (mem_ready) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            word_q  <= 1'b0;
            sx_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
            rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        word_q  <= word;
                        sx_q    <= sign_extend;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
                        fault_q <= split_in;
`endif
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        if (split_q)    beat0_q <= mem_rdata;
                        else if (!we_q) rdata_q <= assemble(mem_rdata, off_q, word_q, sx_q);
                    end
                end
                BEAT1: begin
                    if (mem_ready && !we_q) rdata_q <= assemble(merged, off_q, word_q, sx_q);
                end
                default: ;
            endcase
        end
    end

    assign rdata = rdata_q;
    assign done  = (state_q == RESP);
    assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_bus_align_unit.sv
// Bench for bus_align_unit (DATA_W=16): byte-level memory model, beat scoreboard and load-result scoreboard.
module tb_bus_align_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0, word = 1'b0, sign_extend = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic [15:0] rdata;
  logic        done, busy, fault;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_be;

  bus_align_unit #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .word(word), .sign_extend(sign_extend),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // scoreboard state
  typedef struct { logic [15:0] addr; logic [1:0] be; logic we; logic [15:0] wd; } beat_t;
  beat_t       beat_q[$];
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_lat;
  logic        exp_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // memory responder: bus_mem is the DUT-side memory, model_mem the reference image
  logic [7:0]  bus_mem [0:65535];
  logic [7:0]  model_mem [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;
  int          stall_b0 = 0, stall_b1 = 0;
  int          stall_cnt, beat_idx;

  assign mem_rdata = {bus_mem[mem_addr + 16'd1], bus_mem[mem_addr]};
  assign mem_ready = mem_req && (stall_cnt >= ((beat_idx == 0) ? stall_b0 : stall_b1));

  always @(posedge clk) begin
    if (poke_en) bus_mem[poke_addr] <= poke_data;
    if (mem_req && mem_ready && mem_we) begin
      if (mem_be[0]) bus_mem[mem_addr] <= mem_wdata[7:0];
      if (mem_be[1]) bus_mem[mem_addr + 16'd1] <= mem_wdata[15:8];
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 0;
      beat_idx  <= 0;
    end else if (!busy) begin
      stall_cnt <= 0;
      beat_idx  <= 0;
    end else if (mem_req) begin
      if (mem_ready) begin
        stall_cnt <= 0;
        beat_idx  <= 1;
      end else begin
        stall_cnt <= stall_cnt + 1;
      end
    end
  end

  // beat monitor: every cycle of a beat (including stalls) must match the expected head
  beat_t       mon_b;
  logic [15:0] mon_mask;
  always @(negedge clk) begin
    if (mem_req) begin
      if (beat_q.size() == 0) begin
        check("beat_unexpected", {mem_addr, 14'd0, mem_be}, 32'd0);
      end else begin
        mon_b    = beat_q[0];
        mon_mask = {{8{mon_b.be[1]}}, {8{mon_b.be[0]}}};
        check("beat_addr", mem_addr, mon_b.addr);
        check("beat_be", mem_be, mon_b.be);
        check("beat_we", mem_we, mon_b.we);
        if (mon_b.we) check("beat_wdata", mem_wdata & mon_mask, mon_b.wd & mon_mask);
        if (mem_ready) void'(beat_q.pop_front());
      end
    end
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    model_mem[a] = d;
    poke_addr = a;
    poke_data = d;
    poke_en = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic start_access(input logic w, input logic wd, input logic sx, input logic [15:0] a,
                              input logic [15:0] d, input int s0, input int s1);
    logic [15:0] a0, rot, exp_r;
    logic        off, split, trap;
    logic [7:0]  by;
    beat_t       b;
    a0 = {a[15:1], 1'b0};
    off = a[0];
    split = wd & off;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = split;
`endif
    rot = off ? {d[7:0], d[15:8]} : d;
    if (!trap) begin
      b.addr = a0;
      b.we = w;
      b.wd = rot;
      b.be = (wd && !off) ? 2'b11 : (off ? 2'b10 : 2'b01);
      beat_q.push_back(b);
      if (split) begin
        b.addr = a0 + 16'd2;
        b.be = 2'b01;
        beat_q.push_back(b);
      end
    end
    exp_r = '0;
    if (!trap && !w) begin
      if (wd) exp_r = {model_mem[a + 16'd1], model_mem[a]};
      else begin
        by = model_mem[a];
        exp_r = {{8{sx & by[7]}}, by};
      end
    end
    if (!trap && w) begin
      model_mem[a] = d[7:0];
      if (wd) model_mem[a + 16'd1] = d[15:8];
    end
    exp_q.push_back(exp_r);
    exp_fault = trap;
    exp_lat = trap ? 1 : (2 + s0 + (split ? 1 + s1 : 0));
    stall_b0 = s0;
    stall_b1 = s1;
    @(posedge clk);
    #1;
    req = 1'b1; we = w; word = wd; sign_extend = sx; addr = a; wdata = d;
  endtask

  task automatic finish_access(input string tag);
    int   lat;
    logic got;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check({tag, "_done_seen"}, got, 1'b1);
    if (got) begin
      check({tag, "_latency"}, lat, exp_lat);
      if (exp_q.size() != 0) check({tag, "_rdata"}, rdata, exp_q.pop_front());
      check({tag, "_fault"}, fault, exp_fault);
      check({tag, "_beats_left"}, beat_q.size(), 0);
    end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse_len"}, done, 1'b0);
    check({tag, "_busy_after"}, busy, 1'b0);
    beat_q.delete();
    exp_q.delete();
  endtask

  task automatic access(input string tag, input logic w, input logic wd, input logic sx,
                        input logic [15:0] a, input logic [15:0] d, input int s0, input int s1);
    start_access(w, wd, sx, a, d, s0, s1);
    finish_access(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic [15:0] ra;
    // reset state
    @(negedge clk);
    check("rst_rdata", rdata, 16'h0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_mem_be", mem_be, 2'b00);
    reset = 1'b0;

    for (int i = 0; i < 128; i++) poke(16'(i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 128; i++) poke(16'hFF80 + 16'(i), 8'($urandom_range(0, 255)));

    // directed cases
    poke(16'h0002, 8'h12); poke(16'h0003, 8'hAB); poke(16'h0004, 8'hCD); poke(16'h0005, 8'h34);
    access("mis_load", 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 0, 0);
    access("mis_store", 1'b1, 1'b1, 1'b0, 16'h0005, 16'h1234, 0, 0);
    access("mis_store_rb", 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 0, 0);
    poke(16'h0006, 8'hFF); poke(16'h0007, 8'h80);
    access("byte_sx", 1'b0, 1'b0, 1'b1, 16'h0007, 16'h0000, 0, 0);
    access("byte_zx", 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0000, 0, 0);
    access("byte_lo", 1'b0, 1'b0, 1'b1, 16'h0006, 16'h0000, 1, 0);
    access("byte_store", 1'b1, 1'b0, 1'b0, 16'h0009, 16'hA55A, 0, 0);
    access("byte_store_rb", 1'b0, 1'b1, 1'b0, 16'h0008, 16'h0000, 0, 0);
    access("wrap_stall", 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 3);
    access("trap_mis", 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 0, 0);
    access("trap_aligned", 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 0, 0);

    // reset while the second beat is stalled
    start_access(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 0, 5);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_be == 2'b01) found = 1'b1;
    end
`ifndef MISALIGN_TRAP_EN
    check("rst_mid_reach_beat1", found, 1'b1);
`endif
    #1 reset = 1'b1;
    #1;
    check("rst_mid_mem_req", mem_req, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    req = 1'b0;
    beat_q.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", done, 1'b0);
    end
    access("after_rst", 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 0);

    // random traffic with random stalls
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom_range(0, 63));
      access("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ra, 16'($urandom_range(0, 65535)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
